// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Releases NUM_STAGES active-low stage resets one at a time in
//                ascending order. Every stage is held in reset for HOLD_CYCLES
//                clocks first. The next stage is released only once the
//                current stage reports ready and GAP_CYCLES clocks have passed
//                since its release.
//  Ports       : clock         - system clock
//                reset         - synchronous, active-high
//                sw_reset_req  - software request to restart the sequence
//                stage_ready   - per-stage "initialisation complete"
//                stage_reset_n - per-stage active-low reset (registered)
//                seq_busy      - sequence in progress (registered)
//                seq_done      - all stages released and ready (registered)
//                timeout_err   - sticky stage-ready timeout flag (registered)
//  Options     : RST_SEQ_TIMEOUT_EN - when defined, a stage that stays
//                not-ready for TIMEOUT_CYCLES clocks in WAIT drives the block
//                into FAULT. When undefined, WAIT never times out and
//                timeout_err is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  timeout_err
);

    // Stop elaboration when a parameter would mis-size the counters or the index.
    if (NUM_STAGES < 2 || NUM_STAGES > 8 || HOLD_CYCLES < 1 ||
        GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("reset_sequencer: parameter out of legal range");
    end

    localparam int c_IDX_W     = $clog2(NUM_STAGES);
    localparam int c_CNT_LIMIT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W     = $clog2(c_CNT_LIMIT + 1);

    localparam logic [NUM_STAGES-1:0] c_STAGE0 = NUM_STAGES'(1);

    localparam logic [2:0] c_ST_HOLD    = 3'd0;
    localparam logic [2:0] c_ST_RELEASE = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
    localparam logic [2:0] c_ST_FAULT   = 3'd4;

    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_k;      // index of the stage most recently released
    logic [c_CNT_W-1:0] r_cnt;    // hold count in HOLD, clocks since release otherwise

    logic w_ready_k;
    logic w_gap_met;
    logic w_last_stage;
    logic w_tmo_fire;

    assign w_ready_k    = stage_ready[r_k];
    // Checked before the edge: a count of GAP-1 becomes GAP on the advancing edge.
    assign w_gap_met    = (r_cnt >= c_CNT_W'(GAP_CYCLES - 1));
    assign w_last_stage = (r_k == c_IDX_W'(NUM_STAGES - 1));

    // ------------------------------------------------------------------------
    // Sequencing FSM. All outputs except timeout_err are registered here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || sw_reset_req) begin
            r_state       <= c_ST_HOLD;
            r_k           <= '0;
            r_cnt         <= '0;
            stage_reset_n <= '0;
            seq_busy      <= 1'b1;
            seq_done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (r_cnt == c_CNT_W'(HOLD_CYCLES - 1)) begin
                        // Stage 0 comes out of reset on the edge that enters RELEASE.
                        r_state       <= c_ST_RELEASE;
                        r_k           <= '0;
                        r_cnt         <= '0;
                        stage_reset_n <= c_STAGE0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                c_ST_RELEASE: begin
                    r_state <= c_ST_WAIT;
                    if (r_cnt != {c_CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                c_ST_WAIT: begin
                    if (w_ready_k && w_gap_met) begin
                        if (w_last_stage) begin
                            r_state  <= c_ST_DONE;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end else begin
                            r_state       <= c_ST_RELEASE;
                            r_k           <= r_k + c_IDX_W'(1);
                            r_cnt         <= '0;
                            stage_reset_n <= stage_reset_n | (c_STAGE0 << (r_k + c_IDX_W'(1)));
                        end
                    end else if (w_tmo_fire) begin
                        r_state       <= c_ST_FAULT;
                        stage_reset_n <= '0;
                        seq_busy      <= 1'b0;
                    end else if (r_cnt != {c_CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                // DONE and FAULT are left only through reset or sw_reset_req.
                c_ST_DONE:  r_state <= c_ST_DONE;
                c_ST_FAULT: r_state <= c_ST_FAULT;

                default: begin
                    r_state       <= c_ST_HOLD;
                    r_k           <= '0;
                    r_cnt         <= '0;
                    stage_reset_n <= '0;
                    seq_busy      <= 1'b1;
                    seq_done      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional stage-ready timeout
    // ------------------------------------------------------------------------
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMO_W-1:0] r_tmo;    // clocks spent in WAIT for the current stage

    assign w_tmo_fire = (r_state == c_ST_WAIT) && !w_ready_k &&
                        (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || sw_reset_req) begin
            r_tmo       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (r_state == c_ST_WAIT) begin
                if (r_tmo != {c_TMO_W{1'b1}}) begin
                    r_tmo <= r_tmo + c_TMO_W'(1);
                end
            end else begin
                r_tmo <= '0;
            end
            if (w_tmo_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_fire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed self-checking bench for reset_sequencer with the
//                default parameters (4 stages, hold 8, gap 4, timeout 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       sw_reset_req;
    logic [3:0] stage_ready;
    logic [3:0] stage_reset_n;
    logic       seq_busy;
    logic       seq_done;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer #(
        .NUM_STAGES     (4),
        .HOLD_CYCLES    (8),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (256)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .sw_reset_req  (sw_reset_req),
        .stage_ready   (stage_ready),
        .stage_reset_n (stage_reset_n),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst_n"}, 32'(stage_reset_n), 32'h0);
        check({tag, "_busy"},  32'(seq_busy),      32'h1);
        check({tag, "_done"},  32'(seq_done),      32'h0);
        check({tag, "_err"},   32'(timeout_err),   32'h0);
    endtask

    // Full sequence with every stage ready: edge n is the n-th clock of HOLD.
    // Releases at edges 8, 12, 16, 20; DONE at edge 24.
    task automatic run_full_seq(input string tag);
        logic [3:0] exp_mask;
        for (int n = 1; n <= 24; n++) begin
            tick();
            if      (n < 8)  exp_mask = 4'b0000;
            else if (n < 12) exp_mask = 4'b0001;
            else if (n < 16) exp_mask = 4'b0011;
            else if (n < 20) exp_mask = 4'b0111;
            else             exp_mask = 4'b1111;
            check($sformatf("%s_rst_n_%0d", tag, n), 32'(stage_reset_n), 32'(exp_mask));
            check($sformatf("%s_busy_%0d", tag, n), 32'(seq_busy), (n < 24) ? 32'h1 : 32'h0);
            check($sformatf("%s_done_%0d", tag, n), 32'(seq_done), (n < 24) ? 32'h0 : 32'h1);
        end
        check({tag, "_err"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic pulse_sw();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        sw_reset_req = 1'b0;
        stage_ready  = 4'b1111;

        // Power-on reset for three clocks, then the nominal sequence.
        tick_n(3);
        check_reset_state("por");
        reset = 1'b0;
        run_full_seq("seq1");

        // DONE ignores stage_ready changes.
        stage_ready = 4'b0000;
        tick_n(3);
        check("done_hold_rst_n", 32'(stage_reset_n), 32'hF);
        check("done_hold_done",  32'(seq_done),      32'h1);
        check("done_hold_busy",  32'(seq_busy),      32'h0);
        stage_ready = 4'b1111;

        // Software restart from DONE, then identical timing.
        pulse_sw();
        check_reset_state("sw_done");
        run_full_seq("seq2");

        // Held sw_reset_req keeps the hold counter at zero.
        sw_reset_req = 1'b1;
        tick_n(12);
        check_reset_state("sw_held");
        sw_reset_req = 1'b0;
        run_full_seq("seq3");

        // Stage 1 ready late: release of stage 2 follows ready, not the gap.
        pulse_sw();
        stage_ready = 4'b0001;
        tick_n(12);
        check("late_s1_rel", 32'(stage_reset_n), 32'b0011);
        for (int m = 1; m <= 19; m++) begin
            tick();
            if (stage_reset_n !== 4'b0011)
                check($sformatf("late_wait_%0d", m), 32'(stage_reset_n), 32'b0011);
        end
        check("late_before", 32'(stage_reset_n), 32'b0011);
        stage_ready = 4'b0011;
        tick();
        check("late_s2_rel", 32'(stage_reset_n), 32'b0111);

        // Reset and sw_reset_req together while waiting on stage 2.
        tick_n(3);
        check("midwait_rst_n", 32'(stage_reset_n), 32'b0111);
        reset        = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        check_reset_state("midwait_rst");
        reset        = 1'b0;
        sw_reset_req = 1'b0;
        stage_ready  = 4'b1111;
        run_full_seq("seq4");

`ifdef RST_SEQ_TIMEOUT_EN
        // Stage 2 never ready: FAULT after 256 clocks in WAIT.
        pulse_sw();
        stage_ready = 4'b0011;
        tick_n(16);
        check("tmo_s2_rel", 32'(stage_reset_n), 32'b0111);
        tick_n(256);
        check("tmo_pre_err",   32'(timeout_err),   32'h0);
        check("tmo_pre_rst_n", 32'(stage_reset_n), 32'b0111);
        tick();
        check("tmo_err",   32'(timeout_err),   32'h1);
        check("tmo_rst_n", 32'(stage_reset_n), 32'h0);
        check("tmo_busy",  32'(seq_busy),      32'h0);
        check("tmo_done",  32'(seq_done),      32'h0);
        stage_ready = 4'b1111;
        tick_n(5);
        check("fault_stays_err",   32'(timeout_err),   32'h1);
        check("fault_stays_rst_n", 32'(stage_reset_n), 32'h0);
        pulse_sw();
        check_reset_state("tmo_clear");
        run_full_seq("seq5");
`else
        // Stage 0 never ready: WAIT forever, no timeout.
        pulse_sw();
        stage_ready = 4'b0000;
        tick_n(8);
        check("stuck_rel", 32'(stage_reset_n), 32'b0001);
        for (int blk = 1; blk <= 10; blk++) begin
            tick_n(100);
            check($sformatf("stuck_rst_n_%0d", blk), 32'(stage_reset_n), 32'b0001);
            check($sformatf("stuck_err_%0d", blk),   32'(timeout_err),   32'h0);
            check($sformatf("stuck_busy_%0d", blk),  32'(seq_busy),      32'h1);
        end
        stage_ready = 4'b1111;
        pulse_sw();
        run_full_seq("seq5");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
